// File: rtl/mod_i2s_rx.sv
// rtl/mod_i2s_rx.sv - oversampled I2S / left-justified receiver with short-slot flag
module mod_i2s_rx #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_MAX   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  bclk,
  input  logic                  lrclk,
  input  logic                  data_line,
  output logic [DATA_WIDTH-1:0] data_left,
  output logic [DATA_WIDTH-1:0] data_right,
  output logic                  strobe_left,
  output logic                  strobe_right,
  output logic                  short_err
);

  localparam int CW = $clog2(SLOT_MAX + 1);
  localparam logic [DATA_WIDTH-1:0] MSB_BIT = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] DW_CNT  = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] MAX_CNT = CW'(SLOT_MAX);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;
  state_t state, state_next;

  logic [1:0]            bclk_sync, lr_sync, dat_sync;
  logic                  bclk_prev, bit_ev, lr_smp, dat_smp;
  logic                  prev_lr, have_prev, mode_lat;
  logic [DATA_WIDTH-1:0] shreg, shreg_next, appended, emit_word;
  logic [CW-1:0]         cnt, cnt_next, cnt_inc;
  logic                  boundary, run_active, start_slot;
  logic                  emit, emit_short, slot_lj, emit_left;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      dat_sync  <= '0;
      bclk_prev <= 1'b0;
      bit_ev    <= 1'b0;
      lr_smp    <= 1'b0;
      dat_smp   <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], bclk};
      lr_sync   <= {lr_sync[0], lrclk};
      dat_sync  <= {dat_sync[0], data_line};
      bclk_prev <= bclk_sync[1];
      bit_ev    <= bclk_sync[1] & ~bclk_prev;
      lr_smp    <= lr_sync[1];
      dat_smp   <= dat_sync[1];
    end
  end

  // The very first bit event after reset only establishes the reference lrclk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_lr   <= 1'b0;
      have_prev <= 1'b0;
    end else if (bit_ev) begin
      prev_lr   <= lr_smp;
      have_prev <= 1'b1;
    end
  end

  assign boundary = bit_ev & have_prev & (lr_smp ^ prev_lr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (en && boundary) state_next = S_RUN;
      S_RUN:   if (!en) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    run_active = (state == S_RUN) && en;
    start_slot = (state == S_IDLE) && en && boundary;
  end

  always_comb begin
    slot_lj    = start_slot ? mode : mode_lat;
    cnt_inc    = (cnt == MAX_CNT) ? cnt : cnt + CW'(1);
    appended   = dat_smp ? (shreg | (MSB_BIT >> cnt)) : shreg;
    shreg_next = shreg;
    cnt_next   = cnt;
    emit       = 1'b0;
    emit_word  = '0;
    emit_short = 1'b0;
    emit_left  = (prev_lr == mode_lat);
    if (start_slot || (run_active && boundary)) begin
      if (run_active) begin
        emit = 1'b1;
        // In I2S the boundary bit is the closing bit of the slot being emitted.
        if (mode_lat) begin
          emit_word  = shreg;
          emit_short = (cnt < DW_CNT);
        end else begin
          emit_word  = appended;
          emit_short = (cnt_inc < DW_CNT);
        end
      end
      if (slot_lj) begin
        shreg_next = dat_smp ? MSB_BIT : '0;
        cnt_next   = CW'(1);
      end else begin
        shreg_next = '0;
        cnt_next   = '0;
      end
    end else if (run_active && bit_ev) begin
      shreg_next = appended;
      cnt_next   = cnt_inc;
    end else if (!run_active) begin
      shreg_next = '0;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg        <= '0;
      cnt          <= '0;
      mode_lat     <= 1'b0;
      data_left    <= '0;
      data_right   <= '0;
      strobe_left  <= 1'b0;
      strobe_right <= 1'b0;
      short_err    <= 1'b0;
    end else begin
      shreg        <= shreg_next;
      cnt          <= cnt_next;
      strobe_left  <= emit & emit_left;
      strobe_right <= emit & ~emit_left;
      short_err    <= emit & emit_short;
      if (start_slot) mode_lat <= mode;
      if (emit && emit_left)  data_left  <= emit_word;
      if (emit && !emit_left) data_right <= emit_word;
    end
  end

endmodule

// File: tb/tb_mod_i2s_rx.sv
// tb/tb_mod_i2s_rx.sv - randomized slot-level bench for mod_i2s_rx
module tb_mod_i2s_rx;

  logic        clk = 1'b0;
  logic        reset, en, mode, bclk, lrclk, data_line;
  logic [15:0] data_left, data_right;
  logic        strobe_left, strobe_right, short_err;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] w;
    logic        left;
    logic        sh;
  } ev_t;

  ev_t          ev_q[$];
  int           both_cnt = 0;
  int           lone_cnt = 0;
  logic [127:0] s_vec[16];
  int           s_len[16];
  int           n_slots;

  mod_i2s_rx #(.DATA_WIDTH(16), .SLOT_MAX(32)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .bclk(bclk),
    .lrclk(lrclk), .data_line(data_line), .data_left(data_left),
    .data_right(data_right), .strobe_left(strobe_left),
    .strobe_right(strobe_right), .short_err(short_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (strobe_left && strobe_right) both_cnt++;
      if (short_err && !strobe_left && !strobe_right) lone_cnt++;
      if (strobe_left)       ev_q.push_back({data_left, 1'b1, short_err});
      else if (strobe_right) ev_q.push_back({data_right, 1'b0, short_err});
    end
  end

  function automatic logic [127:0] mk(int len, logic [127:0] val);
    return val << (128 - len);
  endfunction

  function automatic logic [127:0] rnd(int len);
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return (r >> (128 - len)) << (128 - len);
  endfunction

  task automatic drive_bit(input logic lr, input logic d);
    lrclk = lr;
    data_line = d;
    #40 bclk = 1'b1;
    #40 bclk = 1'b0;
  endtask

  // Slot 0 is a lead-in partial slot, the last slot is left open; only the
  // slots in between (or up to the one before drop_slot) are completed words.
  task automatic run_stream(input logic md, input logic lead_lr, input int drop_slot,
                            input int toggle_idx);
    bit          d_q[$];
    int          sk_q[$];
    int          start[16];
    int          last_emit, j;
    logic        lr, el, es, have_l, have_r;
    logic [15:0] ew, last_l, last_r;
    for (int k = 0; k < n_slots; k++) begin
      start[k] = d_q.size();
      for (int p = 0; p < s_len[k]; p++) begin
        d_q.push_back(s_vec[k][127-p]);
        sk_q.push_back(k);
      end
    end
    en = 1'b0;
    mode = md;
    drive_bit(lead_lr, 1'b0);
    drive_bit(lead_lr, 1'b0);
    ev_q.delete();
    both_cnt = 0;
    lone_cnt = 0;
    en = 1'b1;
    for (int i = 0; i < d_q.size(); i++) begin
      j = (md || i + 1 >= d_q.size()) ? i : i + 1;
      lr = lead_lr ^ (sk_q[j] % 2 == 1);
      if (drop_slot > 0 && i == start[drop_slot] + 3) en = 1'b0;
      if (i == toggle_idx) mode = ~mode;
      drive_bit(lr, d_q[i]);
    end
    #400;
    en = 1'b0;
    #50;
    last_emit = (drop_slot > 0) ? drop_slot - 1 : n_slots - 2;
    checks++;
    if (ev_q.size() !== last_emit) begin
      failures++;
      $display("FAIL word_count: got %0d expected %0d", ev_q.size(), last_emit);
    end
    have_l = 1'b0;
    have_r = 1'b0;
    last_l = '0;
    last_r = '0;
    for (int k = 1; k <= last_emit; k++) begin
      ew = s_vec[k][127 -: 16];
      el = ((lead_lr ^ (k % 2 == 1)) == md);
      es = (s_len[k] < 16);
      if (el) begin have_l = 1'b1; last_l = ew; end
      else    begin have_r = 1'b1; last_r = ew; end
      if (k - 1 < ev_q.size()) begin
        checks++;
        if (ev_q[k-1].w !== ew) begin
          failures++;
          $display("FAIL word_data[%0d]: got %h expected %h", k, ev_q[k-1].w, ew);
        end
        checks++;
        if (ev_q[k-1].left !== el) begin
          failures++;
          $display("FAIL word_channel[%0d]: got left=%b expected left=%b", k, ev_q[k-1].left, el);
        end
        checks++;
        if (ev_q[k-1].sh !== es) begin
          failures++;
          $display("FAIL word_short[%0d]: got %b expected %b", k, ev_q[k-1].sh, es);
        end
      end
    end
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL strobe_exclusive: got %0d overlaps expected 0", both_cnt);
    end
    checks++;
    if (lone_cnt !== 0) begin
      failures++;
      $display("FAIL short_coincident: got %0d lone pulses expected 0", lone_cnt);
    end
    if (have_l) begin
      checks++;
      if (data_left !== last_l) begin
        failures++;
        $display("FAIL data_left_hold: got %h expected %h", data_left, last_l);
      end
    end
    if (have_r) begin
      checks++;
      if (data_right !== last_r) begin
        failures++;
        $display("FAIL data_right_hold: got %h expected %h", data_right, last_r);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (data_left !== 16'h0) begin failures++; $display("FAIL reset_data_left: got %h expected 0", data_left); end
    checks++;
    if (data_right !== 16'h0) begin failures++; $display("FAIL reset_data_right: got %h expected 0", data_right); end
    checks++;
    if (strobe_left !== 1'b0) begin failures++; $display("FAIL reset_strobe_left: got %b expected 0", strobe_left); end
    checks++;
    if (strobe_right !== 1'b0) begin failures++; $display("FAIL reset_strobe_right: got %b expected 0", strobe_right); end
    checks++;
    if (short_err !== 1'b0) begin failures++; $display("FAIL reset_short_err: got %b expected 0", short_err); end
    #40 reset = 1'b0;
    #40;
  endtask

  task automatic test_i2s16();
    n_slots = 4;
    s_vec[0] = rnd(5);                s_len[0] = 5;
    s_vec[1] = mk(16, 128'hA5C3);     s_len[1] = 16;
    s_vec[2] = mk(16, 128'h1234);     s_len[2] = 16;
    s_vec[3] = rnd(3);                s_len[3] = 3;
    run_stream(1'b0, 1'b1, 0, -1);
  endtask

  task automatic test_lj24();
    n_slots = 4;
    s_vec[0] = rnd(4);                s_len[0] = 4;
    s_vec[1] = mk(24, 128'hBEEF01);   s_len[1] = 24;
    s_vec[2] = mk(24, 128'h0F0F0F);   s_len[2] = 24;
    s_vec[3] = rnd(3);                s_len[3] = 3;
    run_stream(1'b1, 1'b0, 0, -1);
  endtask

  task automatic test_short();
    n_slots = 4;
    s_vec[0] = rnd(5);                s_len[0] = 5;
    s_vec[1] = mk(12, 128'hABC);      s_len[1] = 12;
    s_vec[2] = rnd(16);               s_len[2] = 16;
    s_vec[3] = rnd(3);                s_len[3] = 3;
    run_stream(1'b0, 1'b1, 0, -1);
  endtask

  task automatic test_overlong();
    n_slots = 5;
    s_vec[0] = rnd(4);                s_len[0] = 4;
    s_vec[1] = rnd(40);               s_len[1] = 40;
    s_vec[1][127 -: 16] = 16'h8001;
    s_vec[2] = rnd(70);               s_len[2] = 70;
    s_vec[3] = rnd(16);               s_len[3] = 16;
    s_vec[4] = rnd(3);                s_len[4] = 3;
    run_stream(1'b0, 1'b1, 0, -1);
  endtask

  task automatic test_reset_mid();
    en = 1'b0;
    mode = 1'b0;
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    ev_q.delete();
    en = 1'b1;
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < 7; i++) drive_bit(1'b0, 1'($urandom_range(0, 1)));
    #20 reset = 1'b1;
    #1;
    checks++;
    if (data_left !== 16'h0) begin failures++; $display("FAIL midreset_data_left: got %h expected 0", data_left); end
    checks++;
    if (data_right !== 16'h0) begin failures++; $display("FAIL midreset_data_right: got %h expected 0", data_right); end
    checks++;
    if ({strobe_left, strobe_right, short_err} !== 3'b000) begin
      failures++;
      $display("FAIL midreset_pulses: got %b expected 000", {strobe_left, strobe_right, short_err});
    end
    #49 reset = 1'b0;
    #40;
    checks++;
    if (ev_q.size() !== 0) begin failures++; $display("FAIL midreset_no_strobe: got %0d words expected 0", ev_q.size()); end
    n_slots = 5;
    s_vec[0] = rnd(4);   s_len[0] = 4;
    for (int k = 1; k < 4; k++) begin s_vec[k] = rnd(16); s_len[k] = 16; end
    s_vec[4] = rnd(3);   s_len[4] = 3;
    run_stream(1'b0, 1'b1, 0, -1);
  endtask

  task automatic test_enable_mode();
    n_slots = 6;
    s_vec[0] = rnd(4);   s_len[0] = 4;
    for (int k = 1; k < 5; k++) begin s_vec[k] = rnd(16); s_len[k] = 16; end
    s_vec[5] = rnd(3);   s_len[5] = 3;
    run_stream(1'b0, 1'b1, 0, 4 + 16 + 5);
    n_slots = 7;
    s_vec[0] = rnd(4);   s_len[0] = 4;
    for (int k = 1; k < 6; k++) begin s_vec[k] = rnd(16); s_len[k] = 16; end
    s_vec[6] = rnd(3);   s_len[6] = 3;
    run_stream(1'b0, 1'b1, 3, 4 + 16 * 3 + 10);
    n_slots = 5;
    s_vec[0] = rnd(5);   s_len[0] = 5;
    for (int k = 1; k < 4; k++) begin s_vec[k] = rnd(16); s_len[k] = 16; end
    s_vec[4] = rnd(3);   s_len[4] = 3;
    run_stream(1'b1, 1'b0, 0, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      n_slots = 7;
      s_len[0] = $urandom_range(3, 6);
      s_vec[0] = rnd(s_len[0]);
      for (int k = 1; k < 6; k++) begin
        s_len[k] = $urandom_range(2, 40);
        s_vec[k] = rnd(s_len[k]);
      end
      s_len[6] = 2;
      s_vec[6] = rnd(2);
      run_stream(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, -1);
    end
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0;
    mode = 1'b0;
    bclk = 1'b0;
    lrclk = 1'b1;
    data_line = 1'b0;
    #43;
    test_reset();
    test_i2s16();
    test_lj24();
    test_short();
    test_overlong();
    test_reset_mid();
    test_enable_mode();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
